// File: rtl/addr_seq_pkg.sv
// Shared encodings for the addressing-mode sequencer: mode codes, FSM states,
// per-step address-generator control words and bus-address select codes.
package addr_seq_pkg;

  typedef enum logic [3:0] {
    MODE_ABS         = 4'd0,
    MODE_ABS_X       = 4'd1,
    MODE_ABS_Y       = 4'd2,
    MODE_DP          = 4'd3,
    MODE_DP_X        = 4'd4,
    MODE_DP_Y        = 4'd5,
    MODE_ABS_LONG    = 4'd6,
    MODE_DP_IND      = 4'd7,
    MODE_DP_IND_Y    = 4'd8,
    MODE_DP_IND_LONG = 4'd9,
    MODE_STK_REL     = 4'd10
  } mode_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FAL, ST_FAH, ST_FAB, ST_DPO, ST_SRO, ST_DPX,
    ST_PTL, ST_PTH, ST_PTB, ST_IXL, ST_IXH, ST_FIN
  } state_e;

  // ADDR_CTRL = {AALCtrl[2:0], AAHCtrl[2:0], ABSCtrl[1:0]}
  localparam logic [7:0] CTL_NONE = 8'h00;
  localparam logic [7:0] CTL_FAL  = 8'h43;
  localparam logic [7:0] CTL_FAH  = 8'h08;
  localparam logic [7:0] CTL_FAB  = 8'h01;
  localparam logic [7:0] CTL_DPO  = 8'hB4;
  localparam logic [7:0] CTL_SRO  = 8'hB7;
  localparam logic [7:0] CTL_DPX  = 8'h90;
  localparam logic [7:0] CTL_IXL  = 8'h20;
  localparam logic [7:0] CTL_IXH  = 8'h04;

  localparam logic [2:0] LPC_NONE = 3'b000;
  localparam logic [2:0] LPC_INC  = 3'b001;

  localparam logic [1:0] SRC_PC = 2'b00;  // program counter
  localparam logic [1:0] SRC_DX = 2'b01;  // DX + ADDR_OFS
  localparam logic [1:0] SRC_AB = 2'b10;  // {AB, AA}

  localparam logic [1:0] IDX_X = 2'b00;
  localparam logic [1:0] IDX_Y = 2'b01;

  // First step of each legal mode; illegal codes jump straight to FIN.
  function automatic state_e first_state(input logic [3:0] mode);
    state_e s;
    case (mode)
      MODE_ABS, MODE_ABS_X, MODE_ABS_Y, MODE_ABS_LONG:                  s = ST_FAL;
      MODE_DP, MODE_DP_X, MODE_DP_Y, MODE_DP_IND, MODE_DP_IND_Y,
      MODE_DP_IND_LONG:                                                 s = ST_DPO;
      MODE_STK_REL:                                                     s = ST_SRO;
      default:                                                          s = ST_FIN;
    endcase
    return s;
  endfunction

  function automatic logic mode_legal(input logic [3:0] mode);
    return (mode <= 4'd10);
  endfunction

endpackage

// File: rtl/addr_seq_decode.sv
// Combinational step ROM: maps the sequencer state to the generator control
// word, PC load, and bus-address select/offset for that cycle.
module addr_seq_decode
  import addr_seq_pkg::*;
(
  input  state_e      state,
  output logic [7:0]  addr_ctrl,
  output logic [2:0]  load_pc,
  output logic [1:0]  addr_src,
  output logic [1:0]  addr_ofs
);

  // One row per state; idle values are the defaults.
  always_comb begin
    addr_ctrl = CTL_NONE;
    load_pc   = LPC_NONE;
    addr_src  = SRC_PC;
    addr_ofs  = 2'd0;
    case (state)
      ST_FAL: begin addr_ctrl = CTL_FAL; load_pc = LPC_INC; end
      ST_FAH: begin addr_ctrl = CTL_FAH; load_pc = LPC_INC; end
      ST_FAB: begin addr_ctrl = CTL_FAB; load_pc = LPC_INC; end
      ST_DPO: begin addr_ctrl = CTL_DPO; load_pc = LPC_INC; end
      ST_SRO: begin addr_ctrl = CTL_SRO; load_pc = LPC_INC; end
      // Direct-page indexing still addresses through DX; {AB,AA} is only
      // presented once the sequence reaches FIN.
      ST_DPX: begin addr_ctrl = CTL_DPX; addr_src = SRC_DX; end
      ST_PTL: begin addr_ctrl = CTL_FAL; addr_src = SRC_DX; addr_ofs = 2'd0; end
      ST_PTH: begin addr_ctrl = CTL_FAH; addr_src = SRC_DX; addr_ofs = 2'd1; end
      ST_PTB: begin addr_ctrl = CTL_FAB; addr_src = SRC_DX; addr_ofs = 2'd2; end
      ST_IXL: begin addr_ctrl = CTL_IXL; addr_src = SRC_AB; end
      ST_IXH: begin addr_ctrl = CTL_IXH; addr_src = SRC_AB; end
      ST_FIN: begin addr_src = SRC_AB; end
      default: ;
    endcase
  end

endmodule

// File: rtl/addr_mode_sequencer.sv
// Moore FSM sequencing the 65C816 address generator through one operand
// address calculation; DONE marks the cycle AA/AB hold the effective address.
//
// START handshake: START is a request sampled on CLK edges with EN=1. It is
// accepted only when the FSM is in IDLE or FIN; MODE/WR are captured on that
// same edge. START in any other state is ignored and need not be held.
module addr_mode_sequencer
  import addr_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        START,
  input  logic [3:0]  MODE,
  input  logic        WR,
  input  logic        E6502,
  input  logic        ALCARRY,
  output logic [7:0]  ADDR_CTRL,
  output logic [1:0]  IND_CTRL,
  output logic [2:0]  LOAD_PC,
  output logic [1:0]  ADDR_SRC,
  output logic [1:0]  ADDR_OFS,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [3:0]  STATE_DBG
);

  state_e      state_q, state_d;
  logic [3:0]  mode_q;
  logic        wr_q;
  logic [1:0]  ind_q;
  logic        err_q;
  logic        accept;

  assign accept = EN && START && (state_q == ST_IDLE || state_q == ST_FIN);

  // State register; EN=0 freezes the sequence in place.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     state_q <= ST_IDLE;
    else if (EN) state_q <= state_d;
  end

  // Mode, store flag, index select and error flag captured on acceptance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q <= 4'd0;
      wr_q   <= 1'b0;
      ind_q  <= IDX_X;
      err_q  <= 1'b0;
    end else if (accept) begin
      mode_q <= MODE;
      wr_q   <= WR;
      ind_q  <= (MODE == MODE_ABS_Y || MODE == MODE_DP_Y || MODE == MODE_DP_IND_Y)
                ? IDX_Y : IDX_X;
      err_q  <= !mode_legal(MODE);
    end
  end

  // Next-state: walk the step list of the latched mode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = first_state(MODE);
      ST_FAL:  state_d = ST_FAH;
      ST_FAH: begin
        case (mode_q)
          MODE_ABS_X, MODE_ABS_Y: state_d = ST_IXL;
          MODE_ABS_LONG:          state_d = ST_FAB;
          default:                state_d = ST_FIN;
        endcase
      end
      ST_FAB:  state_d = ST_FIN;
      ST_DPO: begin
        case (mode_q)
          MODE_DP_X, MODE_DP_Y:                             state_d = ST_DPX;
          MODE_DP_IND, MODE_DP_IND_Y, MODE_DP_IND_LONG:      state_d = ST_PTL;
          default:                                          state_d = ST_FIN;
        endcase
      end
      ST_SRO:  state_d = ST_FIN;
      ST_DPX:  state_d = ST_FIN;
      ST_PTL:  state_d = ST_PTH;
      ST_PTH: begin
        case (mode_q)
          MODE_DP_IND_Y:    state_d = ST_IXL;
          MODE_DP_IND_LONG: state_d = ST_PTB;
          default:          state_d = ST_FIN;
        endcase
      end
      ST_PTB:  state_d = ST_FIN;
      // In emulation, a load whose low-byte add did not carry needs no high fixup.
      ST_IXL:  state_d = (E6502 && !wr_q && !ALCARRY) ? ST_FIN : ST_IXH;
      ST_IXH:  state_d = ST_FIN;
      ST_FIN:  state_d = START ? first_state(MODE) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  addr_seq_decode u_decode (
    .state     (state_q),
    .addr_ctrl (ADDR_CTRL),
    .load_pc   (LOAD_PC),
    .addr_src  (ADDR_SRC),
    .addr_ofs  (ADDR_OFS)
  );

  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_FIN);
  assign ERR       = DONE && err_q;
  assign IND_CTRL  = BUSY ? ind_q : IDX_X;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Bench for addr_mode_sequencer: reference step lists per mode feed an
// expected queue; a monitor compares every cycle's outputs against it.
module tb_addr_mode_sequencer;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST, EN, START, WR, E6502, ALCARRY;
  logic [3:0]  MODE;
  logic [7:0]  ADDR_CTRL;
  logic [1:0]  IND_CTRL, ADDR_SRC, ADDR_OFS;
  logic [2:0]  LOAD_PC;
  logic        BUSY, DONE, ERR;
  logic [3:0]  STATE_DBG;

  always #5 CLK = ~CLK;

  addr_mode_sequencer dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .MODE(MODE), .WR(WR),
    .E6502(E6502), .ALCARRY(ALCARRY), .ADDR_CTRL(ADDR_CTRL), .IND_CTRL(IND_CTRL),
    .LOAD_PC(LOAD_PC), .ADDR_SRC(ADDR_SRC), .ADDR_OFS(ADDR_OFS), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .STATE_DBG(STATE_DBG)
  );

  // ---------------- reference model ----------------
  localparam int FAL = 0, FAH = 1, FAB = 2, DPO = 3, SRO = 4, DPX = 5,
                 PTL = 6, PTH = 7, PTB = 8, IXL = 9, IXH = 10, FIN = 11;

  int          n_vec = 0;
  int          n_err = 0;
  logic [18:0] exp_q[$];   // {ctrl, ind, load_pc, src, ofs, done, err}
  logic [18:0] mon_act;

  function automatic logic [18:0] step_vec(input int s, input logic [1:0] ind, input logic err);
    logic [7:0] c; logic [2:0] l; logic [1:0] src, ofs; logic d;
    c = 8'h00; l = 3'b000; src = 2'b10; ofs = 2'd0; d = 1'b0;
    case (s)
      FAL: begin c = 8'h43; l = 3'b001; src = 2'b00; end
      FAH: begin c = 8'h08; l = 3'b001; src = 2'b00; end
      FAB: begin c = 8'h01; l = 3'b001; src = 2'b00; end
      DPO: begin c = 8'hB4; l = 3'b001; src = 2'b00; end
      SRO: begin c = 8'hB7; l = 3'b001; src = 2'b00; end
      DPX: begin c = 8'h90; src = 2'b01; end
      PTL: begin c = 8'h43; src = 2'b01; ofs = 2'd0; end
      PTH: begin c = 8'h08; src = 2'b01; ofs = 2'd1; end
      PTB: begin c = 8'h01; src = 2'b01; ofs = 2'd2; end
      IXL: c = 8'h20;
      IXH: c = 8'h04;
      default: d = 1'b1;  // FIN
    endcase
    return {c, ind, l, src, ofs, d, d & err};
  endfunction

  task automatic push_seq(input logic [3:0] m, input logic wr, input logic e, input logic alc);
    int st[$];
    logic [1:0] ind;
    logic skip, err;
    ind  = (m == 4'd2 || m == 4'd5 || m == 4'd8) ? 2'b01 : 2'b00;
    skip = e && !wr && !alc;
    err  = (m > 4'd10);
    case (m)
      4'd0:      begin st.push_back(FAL); st.push_back(FAH); end
      4'd1, 4'd2: begin st.push_back(FAL); st.push_back(FAH); st.push_back(IXL);
                       if (!skip) st.push_back(IXH); end
      4'd3:      st.push_back(DPO);
      4'd4, 4'd5: begin st.push_back(DPO); st.push_back(DPX); end
      4'd6:      begin st.push_back(FAL); st.push_back(FAH); st.push_back(FAB); end
      4'd7:      begin st.push_back(DPO); st.push_back(PTL); st.push_back(PTH); end
      4'd8:      begin st.push_back(DPO); st.push_back(PTL); st.push_back(PTH);
                       st.push_back(IXL); if (!skip) st.push_back(IXH); end
      4'd9:      begin st.push_back(DPO); st.push_back(PTL); st.push_back(PTH);
                       st.push_back(PTB); end
      4'd10:     st.push_back(SRO);
      default:   ;
    endcase
    st.push_back(FIN);
    foreach (st[i]) exp_q.push_back(step_vec(st[i], ind, err));
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Compares at the falling edge; the front entry retires when EN lets the FSM advance.
  always @(negedge CLK) begin
    if (!RST) begin
      mon_act = {ADDR_CTRL, IND_CTRL, LOAD_PC, ADDR_SRC, ADDR_OFS, DONE, ERR};
      n_vec++;
      if (BUSY) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_busy: got %h, required idle", mon_act);
        end else begin
          if (mon_act !== exp_q[0]) begin
            n_err++;
            $display("FAIL step t=%0t: got %h, required %h", $time, mon_act, exp_q[0]);
          end
          if (EN) void'(exp_q.pop_front());
        end
      end else if (mon_act !== 19'd0) begin
        n_err++;
        $display("FAIL idle_outputs t=%0t: got %h, required 0", $time, mon_act);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Called #1 after a rising edge with the FSM in IDLE or FIN.
  task automatic start_seq(input logic [3:0] m, input logic wr, input logic e, input logic alc);
    MODE = m; WR = wr; E6502 = e; ALCARRY = alc; EN = 1'b1; START = 1'b1;
    push_seq(m, wr, e, alc);
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Run until at most n expected steps remain; optional random EN stalls.
  task automatic wait_front(input int n, input bit stall);
    int cnt;
    cnt = 0;
    while (exp_q.size() > n && cnt < 200) begin
      EN = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge CLK); #1;
      cnt++;
    end
    EN = 1'b1;
    if (exp_q.size() > n) begin
      n_vec++; n_err++;
      $display("FAIL timeout: %0d steps still pending, required <= %0d", exp_q.size(), n);
      exp_q.delete();
      do_reset();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] m;
    logic wr, e, alc, chain;
    RST = 1'b1; EN = 1'b0; START = 1'b0; MODE = 4'd0; WR = 1'b0; E6502 = 1'b0; ALCARRY = 1'b0;
    #1;
    n_vec++;
    if ({BUSY, DONE, ERR, ADDR_CTRL, IND_CTRL, LOAD_PC, ADDR_SRC, ADDR_OFS} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b ctrl=%h, required all zero", BUSY, ADDR_CTRL);
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0; EN = 1'b1;

    // absolute: FAL, FAH, FIN then idle
    start_seq(4'd0, 1'b0, 1'b0, 1'b0); wait_front(0, 0);
    // absolute,X in emulation: IXH skipped without carry, present with carry
    start_seq(4'd1, 1'b0, 1'b1, 1'b0); wait_front(0, 0);
    start_seq(4'd1, 1'b0, 1'b1, 1'b1); wait_front(0, 0);
    // store forces IXH even without carry
    start_seq(4'd2, 1'b1, 1'b1, 1'b0); wait_front(0, 0);
    // (dp),Y native: six cycles
    start_seq(4'd8, 1'b0, 1'b0, 1'b0); wait_front(0, 0);
    // [dp] with two-cycle stall at PTH
    start_seq(4'd9, 1'b0, 1'b0, 1'b0);
    wait_front(3, 0);
    EN = 1'b0; repeat (2) @(posedge CLK); #1 EN = 1'b1;
    wait_front(0, 0);
    // illegal mode, then stack-relative back-to-back from FIN
    start_seq(4'd12, 1'b0, 1'b0, 1'b0); wait_front(1, 0);
    start_seq(4'd10, 1'b0, 1'b0, 1'b0); wait_front(0, 0);
    // START mid-sequence is ignored and must not relatch WR
    start_seq(4'd8, 1'b0, 1'b1, 1'b0);
    START = 1'b1; MODE = 4'd3; WR = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    wait_front(0, 0);
    // async reset during FAH of absolute long
    start_seq(4'd6, 1'b0, 1'b0, 1'b0);
    wait_front(3, 0);
    RST = 1'b1; #1;
    n_vec++;
    if ({BUSY, DONE, ERR, ADDR_CTRL, IND_CTRL, LOAD_PC, ADDR_SRC, ADDR_OFS} !== 20'd0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b ctrl=%h done=%b, required all zero", BUSY, ADDR_CTRL, DONE);
    end
    exp_q.delete();
    #1 RST = 1'b0;
    @(posedge CLK); #1;

    // randomized sequences with stalls and back-to-back chaining
    for (int i = 0; i < 60; i++) begin
      m     = 4'($urandom_range(0, 15));
      wr    = 1'($urandom_range(0, 1));
      e     = 1'($urandom_range(0, 1));
      alc   = 1'($urandom_range(0, 1));
      chain = 1'($urandom_range(0, 1));
      start_seq(m, wr, e, alc);
      if (chain) wait_front(1, 1);
      else       wait_front(0, 1);
    end
    wait_front(0, 0);
    repeat (2) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
